// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: frame-rate sequencer for the obstacle datapath.
// Owns two obstacle slots, LFSR-driven spawn spacing, a scroll-speed ramp
// and the saturating score. Every piece of state advances only on the
// 120 kHz cycle where a rising edge of clk24Hz is first seen.
//
// Ports
//   clk120kHz   system clock
//   rstn        asynchronous active-low reset
//   clk24Hz     frame clock, synchronous to clk120kHz
//   game_state  0 init, 1 playing, 2/3 over
//   obsN_left   slot N left edge x (16 bit)
//   obsN_valid  slot N occupied
//   obs_speed   current scroll step (pixels per frame)
//   score       frames survived, saturating at 9999

// One obstacle slot: spawns, scrolls left, frees itself at the left edge.
module obstacle_slot #(
  parameter int SPAWN_X = 240
) (
  input  logic        clk120kHz,
  input  logic        rstn,
  input  logic        tick,
  input  logic        clear,
  input  logic        play,
  input  logic        spawn,
  input  logic [3:0]  speed,
  output logic [15:0] left,
  output logic        valid
);
  always_ff @(posedge clk120kHz or negedge rstn) begin
    if (!rstn) begin
      left  <= '0;
      valid <= 1'b0;
    end else if (tick) begin
      if (clear) begin
        left  <= '0;
        valid <= 1'b0;
      end else if (play) begin
        // spawn is only ever raised for a slot that was empty before the tick
        if (spawn) begin
          left  <= 16'(SPAWN_X);
          valid <= 1'b1;
        end else if (valid) begin
          if (left <= {12'd0, speed}) begin
            left  <= '0;
            valid <= 1'b0;
          end else begin
            left  <= left - {12'd0, speed};
          end
        end
      end
    end
  end
endmodule

module obstacle_scheduler #(
  parameter int          SPAWN_X     = 240,
  parameter int          BASE_SPEED  = 8,
  parameter int          MAX_SPEED   = 14,
  parameter int          SPEEDUP_PTS = 100,
  parameter int          MIN_GAP     = 6,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk120kHz,
  input  logic        rstn,
  input  logic        clk24Hz,
  input  logic [1:0]  game_state,
  output logic [15:0] obs0_left,
  output logic        obs0_valid,
  output logic [15:0] obs1_left,
  output logic        obs1_valid,
  output logic [3:0]  obs_speed,
  output logic [13:0] score
);
  localparam int NUM_SLOTS = 2;
  localparam int CW        = $clog2(SPEEDUP_PTS + 1);

  logic                          hist, tick;
  logic [15:0]                   lfsr;
  logic [4:0]                    gap;
  logic [CW-1:0]                 spd_cnt;
  logic                          clear, play, spawn_en;
  logic [NUM_SLOTS-1:0]          spawn;
  logic [NUM_SLOTS-1:0][15:0]    left;
  logic [NUM_SLOTS-1:0]          valid;

  assign tick  = clk24Hz & ~hist;
  assign clear = (game_state == 2'd0);
  assign play  = (game_state == 2'd1);

  // Spawn targets the lowest slot empty before this tick; a slot freed by
  // this tick's move stays unavailable until the next tick.
  assign spawn_en = (gap == 5'd0) && !(&valid);
  assign spawn[0] = spawn_en & ~valid[0];
  assign spawn[1] = spawn_en & valid[0] & ~valid[1];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    obstacle_slot #(.SPAWN_X(SPAWN_X)) u_slot (
      .clk120kHz (clk120kHz),
      .rstn      (rstn),
      .tick      (tick),
      .clear     (clear),
      .play      (play),
      .spawn     (spawn[i]),
      .speed     (obs_speed),
      .left      (left[i]),
      .valid     (valid[i])
    );
  end

  assign obs0_left  = left[0];
  assign obs0_valid = valid[0];
  assign obs1_left  = left[1];
  assign obs1_valid = valid[1];

  always_ff @(posedge clk120kHz or negedge rstn) begin
    if (!rstn) begin
      hist      <= 1'b0;
      lfsr      <= LFSR_SEED;
      gap       <= 5'(MIN_GAP);
      spd_cnt   <= '0;
      obs_speed <= 4'(BASE_SPEED);
      score     <= '0;
    end else begin
      hist <= clk24Hz;
      if (tick) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (clear) begin
          gap       <= 5'(MIN_GAP);
          spd_cnt   <= '0;
          obs_speed <= 4'(BASE_SPEED);
          score     <= '0;
        end else if (play) begin
          // gap == 0 with both slots busy holds at 0 until a slot frees up
          if (gap != 5'd0)  gap <= gap - 5'd1;
          else if (spawn_en) gap <= 5'(MIN_GAP) + {1'b0, lfsr[3:0]};

          if (score != 14'd9999) score <= score + 14'd1;

          if (spd_cnt == CW'(SPEEDUP_PTS - 1)) begin
            spd_cnt <= '0;
            if (obs_speed < 4'(MAX_SPEED)) obs_speed <= obs_speed + 4'd1;
          end else begin
            spd_cnt <= spd_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: random frame timing and game states checked
// every cycle against a frame-level model, plus literal anchor checks.
module tb_obstacle_scheduler;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        c24 = 1'b0;
  logic [1:0]  gs = 2'd0;
  logic [15:0] obs0_left, obs1_left;
  logic        obs0_valid, obs1_valid;
  logic [3:0]  obs_speed;
  logic [13:0] score;

  int checks = 0;
  int errors = 0;

  obstacle_scheduler dut (
    .clk120kHz (clk),
    .rstn      (rstn),
    .clk24Hz   (c24),
    .game_state(gs),
    .obs0_left (obs0_left),
    .obs0_valid(obs0_valid),
    .obs1_left (obs1_left),
    .obs1_valid(obs1_valid),
    .obs_speed (obs_speed),
    .score     (score)
  );

  always #5 clk = ~clk;

  // frame-level model
  int          mx[2];
  bit          mv[2];
  int          mspd = 8, mscore = 0, mgap = 6, mcnt = 0;
  logic [15:0] mlfsr = 16'hACE1;
  bit          mhist = 1'b0;

  task automatic model_reset();
    mx[0] = 0; mx[1] = 0; mv[0] = 0; mv[1] = 0;
    mspd = 8; mscore = 0; mgap = 6; mcnt = 0;
    mlfsr = 16'hACE1; mhist = 0;
  endtask

  task automatic model_frame(int state);
    int free_slot;
    if (state == 0) begin
      mx[0] = 0; mx[1] = 0; mv[0] = 0; mv[1] = 0;
      mspd = 8; mscore = 0; mgap = 6; mcnt = 0;
    end else if (state == 1) begin
      free_slot = -1;
      for (int i = 1; i >= 0; i--) if (!mv[i]) free_slot = i;
      for (int i = 0; i < 2; i++)
        if (mv[i]) begin
          if (mx[i] <= mspd) begin mx[i] = 0; mv[i] = 0; end
          else mx[i] = mx[i] - mspd;
        end
      if (mgap == 0) begin
        if (free_slot >= 0) begin
          mx[free_slot] = 240; mv[free_slot] = 1;
          mgap = 6 + (mlfsr % 16);
        end
      end else mgap = mgap - 1;
      if (mscore < 9999) mscore++;
      mcnt++;
      if (mcnt == 100) begin
        mcnt = 0;
        if (mspd < 14) mspd++;
      end
    end
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else begin
        if (c24 && !mhist) model_frame(int'(gs));
        mhist = c24;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      chk("obs0_left",  int'(obs0_left),  mx[0]);
      chk("obs0_valid", int'(obs0_valid), int'(mv[0]));
      chk("obs1_left",  int'(obs1_left),  mx[1]);
      chk("obs1_valid", int'(obs1_valid), int'(mv[1]));
      chk("obs_speed",  int'(obs_speed),  mspd);
      chk("score",      int'(score),      mscore);
    end
  end

  task automatic tick(int h, int l);
    @(negedge clk); #2 c24 = 1'b1;
    repeat (h) @(negedge clk);
    #2 c24 = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic chk_cleared(string tag);
    chk({tag, "_v0"},  int'(obs0_valid), 0);
    chk({tag, "_l0"},  int'(obs0_left),  0);
    chk({tag, "_v1"},  int'(obs1_valid), 0);
    chk({tag, "_l1"},  int'(obs1_left),  0);
    chk({tag, "_spd"}, int'(obs_speed),  8);
    chk({tag, "_scr"}, int'(score),      0);
  endtask

  int r, hold_score, hold_x0, hold_x1;

  initial begin
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk_cleared("reset");

    // first spawn after reset, then first move
    gs = 2'd1;
    repeat (7) tick(1, 1);
    chk("t7_v0", int'(obs0_valid), 1);
    chk("t7_l0", int'(obs0_left), 240);
    chk("t7_v1", int'(obs1_valid), 0);
    tick(1, 1);
    chk("t8_l0", int'(obs0_left), 232);
    chk("t8_scr", int'(score), 8);
    repeat (40) tick(1, 2);

    // reset mid-frame with clk24Hz high and slots live
    @(negedge clk); #2 c24 = 1'b1;
    @(negedge clk); #2 rstn = 1'b0;
    @(negedge clk);
    chk_cleared("midrst");
    #2 rstn = 1'b1;
    repeat (3) @(negedge clk);
    #2 c24 = 1'b0;
    @(negedge clk);
    chk("midrst_scr", int'(score), 1);

    // speed ramp from a fresh init
    gs = 2'd0; tick(1, 1);
    chk_cleared("init");
    gs = 2'd1;
    tick(10, 2);
    chk("longhi_scr", int'(score), 1);
    repeat (98) tick(1, 1);
    chk("t99_spd", int'(obs_speed), 8);
    tick(1, 1);
    chk("t100_spd", int'(obs_speed), 9);
    repeat (500) tick(1, 1);
    chk("t600_spd", int'(obs_speed), 14);
    repeat (100) tick(1, 1);
    chk("t700_spd", int'(obs_speed), 14);

    // over states hold everything
    hold_score = mscore; hold_x0 = mx[0]; hold_x1 = mx[1];
    gs = 2'd3;
    repeat (50) tick(1, 1);
    gs = 2'd2;
    repeat (20) tick(2, 1);
    chk("over_scr", int'(score), hold_score);
    chk("over_l0",  int'(obs0_left), hold_x0);
    chk("over_l1",  int'(obs1_left), hold_x1);
    chk("over_spd", int'(obs_speed), 14);
    gs = 2'd0; tick(1, 1);
    chk_cleared("over2init");

    // randomized game states, frame timing and resets
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39);
      if (r < 30)      gs = 2'd1;
      else if (r < 34) gs = 2'd3;
      else if (r < 36) gs = 2'd2;
      else if (r < 39) gs = 2'd0;
      else begin
        @(negedge clk); #2 rstn = 1'b0;
        @(negedge clk); #2 rstn = 1'b1;
      end
      tick($urandom_range(1, 4), $urandom_range(1, 4));
    end

    // score saturation
    gs = 2'd0; tick(1, 1);
    gs = 2'd1;
    repeat (10005) tick(1, 1);
    chk("sat_scr", int'(score), 9999);
    chk("sat_spd", int'(obs_speed), 14);
    tick(1, 1);
    chk("sat_scr2", int'(score), 9999);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
